// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline stage with a one-entry skid buffer (REG=1)
// or a pure wire-through (REG=0).
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 18,
  parameter bit          REG   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       count
);

  if (REG) begin : g_reg
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_nxt;
    logic             s_hs;
    logic             m_hs;

    // Handshake flags come from state only; flush and reset gate them off.
    assign s_ready = rst_n & ~flush & (state != FULL);
    assign m_valid = ~flush & (state != EMPTY);
    assign m_data  = main_q;
    assign s_hs    = s_valid & s_ready;
    assign m_hs    = m_valid & m_ready;

    always_comb begin
      count = 2'd0;
      case (state)
        BUSY:    count = 2'd1;
        FULL:    count = 2'd2;
        default: count = 2'd0;
      endcase
    end

    // Next-state and storage update; skid only fills when main is stalled.
    always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
        state_nxt = EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (s_hs) begin
              main_nxt  = s_data;
              state_nxt = BUSY;
            end
          end
          BUSY: begin
            case ({s_hs, m_hs})
              2'b11: main_nxt = s_data;
              2'b10: begin
                skid_nxt  = s_data;
                state_nxt = FULL;
              end
              2'b01:   state_nxt = EMPTY;
              default: state_nxt = BUSY;
            endcase
          end
          FULL: begin
            if (m_hs) begin
              main_nxt  = skid_q;
              state_nxt = BUSY;
            end
          end
          default: state_nxt = EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= EMPTY;
        main_q <= '0;
        skid_q <= '0;
      end else begin
        state  <= state_nxt;
        main_q <= main_nxt;
        skid_q <= skid_nxt;
      end
    end
  end else begin : g_wire
    logic unused_ctrl;

    assign m_data      = s_data;
    assign m_valid     = s_valid;
    assign s_ready     = m_ready;
    assign count       = 2'd0;
    assign unused_ctrl = ^{clk, rst_n, flush};
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random-backpressure bench for pipe_skid_reg, plus a REG=0
// wire-through instance.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [17:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  count;

  logic        p_flush;
  logic [17:0] p_s_data;
  logic        p_s_valid;
  logic        p_s_ready;
  logic [17:0] p_m_data;
  logic        p_m_valid;
  logic        p_m_ready;
  logic [1:0]  p_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] q[$];
  int          mdl_cnt;

  pipe_skid_reg #(.WIDTH(18), .REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count)
  );

  pipe_skid_reg #(.WIDTH(18), .REG(1'b0)) dut_wire (
    .clk(clk), .rst_n(rst_n), .flush(p_flush),
    .s_data(p_s_data), .s_valid(p_s_valid), .s_ready(p_s_ready),
    .m_data(p_m_data), .m_valid(p_m_valid), .m_ready(p_m_ready),
    .count(p_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    p_flush = 1'b0; p_s_data = '0; p_s_valid = 1'b0; p_m_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    #9;
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", 32'(s_ready), 32'd1);
    chk("rel_m_valid", 32'(m_valid), 32'd0);

    // Stream 1..4 at full rate
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_data = 18'(i);
      cyc();
      chk("str_data",  32'(m_data),  32'(i));
      chk("str_valid", 32'(m_valid), 32'd1);
      chk("str_count", 32'(count),   32'd1);
      chk("str_ready", 32'(s_ready), 32'd1);
    end
    s_valid = 1'b0;
    cyc();
    chk("str_end_valid", 32'(m_valid), 32'd0);
    chk("str_end_count", 32'(count),   32'd0);
    chk("str_end_data",  32'(m_data),  32'd4);

    // Stall into skid: 5 in main, 6 offered while m_ready drops
    s_valid = 1'b1; s_data = 18'd5; m_ready = 1'b0;
    cyc();
    chk("stl_busy_data",  32'(m_data), 32'd5);
    chk("stl_busy_count", 32'(count),  32'd1);
    s_data = 18'd6;
    cyc();
    chk("stl_full_count", 32'(count),   32'd2);
    chk("stl_full_ready", 32'(s_ready), 32'd0);
    chk("stl_full_data",  32'(m_data),  32'd5);
    chk("stl_full_valid", 32'(m_valid), 32'd1);
    s_data = 18'd99;
    cyc();
    chk("stl_hold_data",  32'(m_data), 32'd5);
    chk("stl_hold_count", 32'(count),  32'd2);
    s_valid = 1'b0; m_ready = 1'b1;
    cyc();
    chk("drn1_data",  32'(m_data),  32'd6);
    chk("drn1_ready", 32'(s_ready), 32'd1);
    chk("drn1_count", 32'(count),   32'd1);
    cyc();
    chk("drn2_valid", 32'(m_valid), 32'd0);
    chk("drn2_count", 32'(count),   32'd0);

    // Flush while FULL with 7, 8
    s_valid = 1'b1; s_data = 18'd7; m_ready = 1'b0;
    cyc();
    s_data = 18'd8;
    cyc();
    chk("fl_pre_count", 32'(count), 32'd2);
    flush = 1'b1; s_data = 18'd9; m_ready = 1'b1;
    #1;
    chk("fl_s_ready", 32'(s_ready), 32'd0);
    chk("fl_m_valid", 32'(m_valid), 32'd0);
    cyc();
    flush = 1'b0; s_valid = 1'b0;
    #1;
    chk("fl_post_count", 32'(count),   32'd0);
    chk("fl_post_valid", 32'(m_valid), 32'd0);
    chk("fl_post_ready", 32'(s_ready), 32'd1);
    cyc();
    chk("fl_idle_valid", 32'(m_valid), 32'd0);
    chk("fl_idle_count", 32'(count),   32'd0);

    // Async reset while FULL
    s_valid = 1'b1; s_data = 18'h11; m_ready = 1'b0;
    cyc();
    s_data = 18'h12;
    cyc();
    s_valid = 1'b0;
    chk("ar_pre_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_m_valid", 32'(m_valid), 32'd0);
    chk("ar_s_ready", 32'(s_ready), 32'd0);
    chk("ar_count",   32'(count),   32'd0);
    chk("ar_m_data",  32'(m_data),  32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ar_rel_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_data = 18'h2AAAA; m_ready = 1'b1;
    cyc();
    chk("ar_new_data",  32'(m_data),  32'h2AAAA);
    chk("ar_new_valid", 32'(m_valid), 32'd1);
    s_valid = 1'b0;
    cyc();
    chk("ar_end_count", 32'(count), 32'd0);

    // Random backpressure against a queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      s_valid = ($urandom_range(0, 9) < 6);
      m_ready = ($urandom_range(0, 9) < 6);
      s_data  = 18'($urandom);
      #1;
      mdl_cnt = q.size();
      chk("rnd_count", 32'(count),   32'(mdl_cnt));
      chk("rnd_ready", 32'(s_ready), 32'(mdl_cnt != 2));
      chk("rnd_valid", 32'(m_valid), 32'(mdl_cnt != 0));
      if (mdl_cnt != 0) chk("rnd_data", 32'(m_data), 32'(q[0]));
      if (m_ready && mdl_cnt != 0) void'(q.pop_front());
      if (s_valid && mdl_cnt != 2) q.push_back(s_data);
      cyc();
    end
    s_valid = 1'b0; m_ready = 1'b0;

    // REG=0 wire-through, flush must have no effect
    for (int i = 0; i < 8; i++) begin
      p_s_valid = 1'((i >> 0) & 1);
      p_m_ready = 1'((i >> 1) & 1);
      p_flush   = 1'((i >> 2) & 1);
      p_s_data  = 18'(i * 32'h0AB3 + 5);
      #1;
      chk("w_s_ready", 32'(p_s_ready), 32'((i >> 1) & 1));
      chk("w_m_valid", 32'(p_m_valid), 32'(i & 1));
      chk("w_m_data",  32'(p_m_data),  32'(18'(i * 32'h0AB3 + 5)));
      chk("w_count",   32'(p_count),   32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
